// File: rtl/hf_half_adder.sv
// Registered 1-bit half adder (s = a ^ b, c = a & b) with one cycle of latency.
// Define HF_CARRY_CNT_EN to build the saturating carry-event counter.
module hf_half_adder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             s,
    output logic             c,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("hf_half_adder: CNT_W must be in 1..32");
    end

    logic s_q, c_q, out_valid_q;
    logic carry;

    assign carry = a & b;

    // Result flops hold their value on cycles without an accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q <= a ^ b;
                c_q <= carry;
            end
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = out_valid_q;

`ifdef HF_CARRY_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-edge increment; the count sticks at CntMax.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && carry && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign carry_cnt      = '0;
`endif

endmodule

// File: tb/tb_hf_half_adder.sv
// Self-checking bench for hf_half_adder: directed test-plan sequences plus random
// stimulus checked every cycle against an arithmetic reference model.
module tb_hf_half_adder;

    localparam int unsigned CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HF_CARRY_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             in_valid = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             s, c, out_valid;
    logic [CNT_W-1:0] carry_cnt;

    int tests = 0;
    int fails = 0;

    hf_half_adder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .cnt_clr   (cnt_clr),
        .s         (s),
        .c         (c),
        .out_valid (out_valid),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sum of the two bits split into low bit and carry.
    int m_s, m_c, m_ov, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s   <= 0;
            m_c   <= 0;
            m_ov  <= 0;
            m_cnt <= 0;
        end else begin
            m_ov <= int'(in_valid);
            if (in_valid) begin
                m_s <= (int'(a) + int'(b)) % 2;
                m_c <= (int'(a) + int'(b)) / 2;
            end
            if (CNT_EN) begin
                if (cnt_clr) m_cnt <= 0;
                else if (in_valid && (int'(a) + int'(b)) == 2 && m_cnt < CNT_MAX)
                    m_cnt <= m_cnt + 1;
            end
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("model_s", int'(s), m_s);
        check("model_c", int'(c), m_c);
        check("model_out_valid", int'(out_valid), m_ov);
        check("model_carry_cnt", int'(carry_cnt), m_cnt);
    end

    task automatic step(input logic ia, input logic ib, input logic iv, input logic ic);
        @(negedge clk);
        a        = ia;
        b        = ib;
        in_valid = iv;
        cnt_clr  = ic;
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_exp(input int n);
        return CNT_EN ? n : 0;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_s", int'(s), 0);
        check("reset_c", int'(c), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_cnt", int'(carry_cnt), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Truth-table sweep
        step(0, 0, 1, 0);
        check("sweep00_s", int'(s), 0); check("sweep00_c", int'(c), 0);
        check("sweep00_ov", int'(out_valid), 1);
        step(0, 1, 1, 0);
        check("sweep01_s", int'(s), 1); check("sweep01_c", int'(c), 0);
        step(1, 0, 1, 0);
        check("sweep10_s", int'(s), 1); check("sweep10_c", int'(c), 0);
        step(1, 1, 1, 0);
        check("sweep11_s", int'(s), 0); check("sweep11_c", int'(c), 1);
        check("sweep11_cnt", int'(carry_cnt), cnt_exp(1));

        // Hold on in_valid=0
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        check("hold_s", int'(s), 0); check("hold_c", int'(c), 1);
        check("hold_ov", int'(out_valid), 0);
        check("hold_cnt", int'(carry_cnt), cnt_exp(2));

        // Saturation then clear-priority
        step(0, 0, 1, 1);
        check("clr_cnt", int'(carry_cnt), 0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, 1, 0);
            check($sformatf("sat_cnt_%0d", i), int'(carry_cnt), cnt_exp(i < 3 ? i : 3));
        end
        step(1, 1, 1, 1);
        check("clr_prio_cnt", int'(carry_cnt), 0);
        check("clr_prio_c", int'(c), 1);

        // Async reset between edges
        step(0, 1, 1, 0);
        check("pre_rst_s", int'(s), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_s", int'(s), 0);
        check("async_rst_c", int'(c), 0);
        check("async_rst_ov", int'(out_valid), 0);
        check("async_rst_cnt", int'(carry_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, checked by the model compare
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
